// File: rtl/alu_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler_if
// Bundles the command and response handshakes of the shared-ALU scheduler.
//   req_valid  [NUM_REQ]     requester i has a command
//   req_data   [10*NUM_REQ]  slot i = {op[1:0], b[3:0], a[3:0]}
//   req_ready  [NUM_REQ]     one-hot grant/accept from the scheduler
//   rsp_valid                result available
//   rsp_ready                downstream accepts result
//   rsp_result [9]           operation result
//   rsp_id     [ID_W]        index of the requester that issued the command
//   rsp_dbz                  divide-by-zero flag, qualified by rsp_valid
// Modports: master = requester/consumer side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [10*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8:0]            rsp_result;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_dbz;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_dbz
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id, rsp_dbz
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
// Round-robin scheduler sharing one 4-bit add/sub/mul/div datapath among
// NUM_REQ command sources. One command is in flight at a time:
// IDLE (arbitrate + accept) -> EXEC (1 or MULDIV_CYCLES cycles) -> RESP.
// Ports:
//   clk    in   clock, all logic on posedge
//   reset  in   synchronous, active-high
//   bus    slave modport of alu_rr_scheduler_if (command + response handshakes)
//   busy   out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int MULDIV_CYCLES = 3,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    alu_rr_scheduler_if.slave   bus,
    output logic                busy
);
    // CW holds last_grant + 1 + offset (up to 2*NUM_REQ-1) without overflow.
    localparam int CW    = ID_W + 1;
    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [3:0]      a_q, a_d;
    logic [3:0]      b_q, b_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [8:0]      rsp_result_q, rsp_result_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            rsp_dbz_q, rsp_dbz_d;

    // ---------------------------------------------------------------------
    // Command slots
    // ---------------------------------------------------------------------
    logic [9:0] cmd_slot [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign cmd_slot[gi] = bus.req_data[10*gi +: 10];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Round-robin arbiter: rotate the request vector so that bit 0 is the
    // requester right after last_grant, find the lowest set bit, then map
    // the offset back to an absolute index modulo NUM_REQ.
    // ---------------------------------------------------------------------
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [CW-1:0]        shamt;
    logic [CW-1:0]        offset;
    logic [CW-1:0]        grant_sum;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]   ready_vec;

    assign req_dbl     = {bus.req_valid, bus.req_valid};
    assign shamt       = CW'(last_grant_q) + CW'(1);
    assign req_rot     = NUM_REQ'(req_dbl >> shamt);
    assign grant_found = |bus.req_valid;

    always_comb begin
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = CW'(k);
            end
        end
    end

    assign grant_sum = shamt + offset;
    assign grant_idx = (grant_sum >= CW'(NUM_REQ)) ? ID_W'(grant_sum - CW'(NUM_REQ))
                                                   : ID_W'(grant_sum);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign ready_vec[gi] = (state_q == IDLE) && grant_found &&
                                   (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign bus.req_ready = ready_vec;

    // ---------------------------------------------------------------------
    // ALU datapath on the latched operands
    // ---------------------------------------------------------------------
    logic [8:0] alu_result;
    logic       alu_dbz;

    always_comb begin
        alu_result = '0;
        alu_dbz    = 1'b0;
        case (op_q)
            OP_ADD: alu_result = {5'd0, a_q} + {5'd0, b_q};
            OP_SUB: alu_result = {5'd0, a_q} - {5'd0, b_q};
            OP_MUL: alu_result = {1'b0, {4'd0, a_q} * {4'd0, b_q}};
            default: begin
                if (b_q == 4'd0) begin
                    alu_result = 9'h1FF;
                    alu_dbz    = 1'b1;
                end else begin
                    alu_result = {5'd0, a_q / b_q};
                end
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state / datapath-load logic
    // ---------------------------------------------------------------------
    logic exec_done;

    // add/sub finish after one EXEC cycle; mul/div after MULDIV_CYCLES.
    assign exec_done = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                       (cnt_q == CNT_W'(MULDIV_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_dbz_d    = rsp_dbz_q;

        case (state_q)
            IDLE: begin
                // grant_found implies req_valid[g] & req_ready[g]: accept edge.
                if (grant_found) begin
                    {op_d, b_d, a_d} = cmd_slot[grant_idx];
                    id_d             = grant_idx;
                    last_grant_d     = grant_idx;
                    cnt_d            = '0;
                    state_d          = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    rsp_result_d = alu_result;
                    rsp_dbz_d    = alu_dbz;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            rsp_dbz_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_dbz_q    <= rsp_dbz_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_dbz    = rsp_dbz_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Round-robin scheduler that shares one 4-bit ALU datapath (add/sub/mul/div) among NUM_REQ command sources.
- Each source presents a 10-bit command with a valid/ready handshake. The scheduler grants one source, sequences the single- or multi-cycle operation, and returns a 9-bit result tagged with the source id.
- Sits between the input command FIFOs and the result FIFO; it replaces direct FIFO-to-ALU wiring.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MULDIV_CYCLES, 3, EXEC cycles for mul/div (>=1).
- ID_W, $clog2(NUM_REQ), width of rsp_id.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  bit i: requester i has a command.
- req_data  in  10*NUM_REQ  slot i = bits [10i+9:10i]; fields {op[9:8], b[7:4], a[3:0]}.
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  downstream accepts result.
- rsp_result  out  9  operation result.
- rsp_id  out  ID_W  index of the requester that issued the command.
- rsp_dbz  out  1  divide-by-zero flag, qualified by rsp_valid.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (synchronous, sampled on posedge clk):
  - state=IDLE; rsp_valid=0, rsp_result=0, rsp_id=0, rsp_dbz=0, busy=0; cnt=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset asserted mid-operation aborts the command: no response, latched command discarded.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search req_valid starting at last_grant+1, wrapping modulo NUM_REQ. The first set bit g wins.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0. With no valid request, req_ready=0.
  - On the accept edge (req_valid[g] & req_ready[g]): latch op, a, b and g; last_grant<=g; cnt<=0; go to EXEC.
  - req_data is sampled only on the accept edge. A requester may drop valid before being granted, with no side effect.
- EXEC:
  - req_ready=0 throughout.
  - op 0 (add) and op 1 (sub): one EXEC cycle, then RESP.
  - op 2 (mul) and op 3 (div): cnt increments each cycle. When cnt==MULDIV_CYCLES-1, load the result and go to RESP.
- RESP:
  - rsp_valid=1. rsp_result, rsp_id and rsp_dbz are held stable until rsp_ready=1.
  - On the edge where rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE.
  - No same-cycle accept of a new command; the next grant happens at the earliest in the following IDLE cycle.
  - Throughput is one command per 3 cycles (add/sub) or MULDIV_CYCLES+2 cycles (mul/div) with rsp_ready tied high.
- Latency from the accept edge to first rsp_valid=1 cycle: add/sub 2 cycles; mul/div MULDIV_CYCLES+1 cycles.
- Arithmetic (a, b unsigned 4-bit, result 9-bit):
  - add: zero-extended sum, 0..30.
  - sub: (a-b) mod 512 (two's complement wrap, e.g. 3-5 = 9'h1FE).
  - mul: 8-bit product, zero-extended.
  - div: floor(a/b), rsp_dbz=0. If b==0: result=9'h1FF and rsp_dbz=1.
- Round-robin pointer updates only on an accept. Requests held during EXEC/RESP are not lost; they are arbitrated in the next IDLE.

Test Plan:
1. Reset, then req_valid=0001 with req0 = add a=9, b=7; rsp_ready=1 -> req_ready=0001 in the accept cycle; rsp_valid high 2 cycles later with rsp_result=16, rsp_id=0, rsp_dbz=0; busy high for 2 cycles.
2. req1 = sub a=3, b=5 -> rsp_result=9'h1FE, rsp_id=1. req2 = mul a=15, b=15 -> rsp_result=225, rsp_id=2, rsp_valid MULDIV_CYCLES+1=4 cycles after accept, req_ready=0000 throughout EXEC.
3. All four requesters hold valid with add commands a=i, b=1; rsp_ready=1 for 16 cycles -> grant order 0,1,2,3,0; responses 1,2,3,4,1 with matching rsp_id; a new accept every 3 cycles.
4. div a=13, b=4 -> rsp_result=3, rsp_dbz=0. div a=13, b=0 -> rsp_result=9'h1FF, rsp_dbz=1, rsp_valid after 4 cycles.
5. Backpressure: rsp_ready=0 for 5 cycles in RESP while req3 is valid -> rsp outputs constant, req_ready=0000. After rsp_ready=1, state returns to IDLE and req3 is accepted the cycle after the handshake.
6. Reset: assert reset during the 2nd EXEC cycle of a mul -> next cycle rsp_valid=0, busy=0, state IDLE; the first grant after release goes to requester 0 when all requesters are valid.
